// File: rtl/aes1_encipher_block.sv
// rtl/aes1_encipher_block.sv - iterative AES-128/256 encipher datapath with shared S-box port
// One 32-bit word per cycle through the external S-box; four SBOX cycles then one MAIN cycle per round.
module aes1_encipher_block (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);
   localparam logic [3:0] AES128_ROUNDS = 4'ha;
   localparam logic [3:0] AES256_ROUNDS = 4'he;

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_SBOX, S_MAIN} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_w [4];
   logic [31:0] w_w_nxt [4];
   logic [31:0] w_sr [4];
   logic [3:0]  r_round_ctr, w_round_nxt;
   logic [1:0]  r_sword_ctr, w_sword_nxt;
   logic        r_keylen, w_keylen_nxt;
   logic        r_ready, w_ready_nxt;
   logic [3:0]  w_nr;
   logic        w_last;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Row r of column c comes from column (c+r) mod 4
   assign w_sr[0] = {r_w[0][31:24], r_w[1][23:16], r_w[2][15:8], r_w[3][7:0]};
   assign w_sr[1] = {r_w[1][31:24], r_w[2][23:16], r_w[3][15:8], r_w[0][7:0]};
   assign w_sr[2] = {r_w[2][31:24], r_w[3][23:16], r_w[0][15:8], r_w[1][7:0]};
   assign w_sr[3] = {r_w[3][31:24], r_w[0][23:16], r_w[1][15:8], r_w[2][7:0]};

   assign w_nr      = r_keylen ? AES256_ROUNDS : AES128_ROUNDS;
   assign w_last    = !(r_round_ctr < w_nr);
   assign round     = r_round_ctr;
   assign ready     = r_ready;
   assign new_block = {r_w[0], r_w[1], r_w[2], r_w[3]};

   always_comb begin
      w_state_nxt  = r_state;
      w_round_nxt  = r_round_ctr;
      w_sword_nxt  = r_sword_ctr;
      w_keylen_nxt = r_keylen;
      w_ready_nxt  = r_ready;
      for (int i = 0; i < 4; i++) w_w_nxt[i] = r_w[i];
      sboxw = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (next) begin
               w_keylen_nxt = keylen;
               w_round_nxt  = 4'd0;
               w_ready_nxt  = 1'b0;
               w_state_nxt  = S_INIT;
            end
         end
         S_INIT: begin
            for (int i = 0; i < 4; i++)
               w_w_nxt[i] = block[127-32*i -: 32] ^ round_key[127-32*i -: 32];
            w_round_nxt = 4'd1;
            w_sword_nxt = 2'd0;
            w_state_nxt = S_SBOX;
         end
         S_SBOX: begin
            sboxw                = r_w[r_sword_ctr];
            w_w_nxt[r_sword_ctr] = new_sboxw;
            w_sword_nxt          = r_sword_ctr + 2'd1;
            if (r_sword_ctr == 2'd3) w_state_nxt = S_MAIN;
         end
         S_MAIN: begin
            w_sword_nxt = 2'd0;
            for (int i = 0; i < 4; i++)
               w_w_nxt[i] = (w_last ? w_sr[i] : mix_col(w_sr[i])) ^ round_key[127-32*i -: 32];
            // Final round leaves the counter at Nr so it never passes 14
            if (w_last) begin
               w_ready_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_round_nxt = r_round_ctr + 4'd1;
               w_state_nxt = S_SBOX;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_round_ctr <= 4'd0;
         r_sword_ctr <= 2'd0;
         r_keylen    <= 1'b0;
         r_ready     <= 1'b1;
         for (int i = 0; i < 4; i++) r_w[i] <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_round_ctr <= w_round_nxt;
         r_sword_ctr <= w_sword_nxt;
         r_keylen    <= w_keylen_nxt;
         r_ready     <= w_ready_nxt;
         for (int i = 0; i < 4; i++) r_w[i] <= w_w_nxt[i];
      end
   end
endmodule

// File: tb/tb_aes1_encipher_block.sv
// tb/tb_aes1_encipher_block.sv - bench for aes1_encipher_block with byte-level AES reference model
module tb_aes1_encipher_block;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         next = 1'b0;
   logic         keylen = 1'b0;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] block = 128'h0;
   logic [127:0] new_block;
   logic         ready;

   logic [7:0]   sb [256];
   logic [127:0] rk [16];
   logic [127:0] pre [16];
   logic [7:0]   ms [16];
   logic [127:0] hold_ct;
   int           tests = 0;
   int           fails = 0;

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes1_encipher_block dut (
      .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round),
      .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw), .block(block),
      .new_block(new_block), .ready(ready)
   );

   always #5 clk = ~clk;

   assign round_key = rk[round];
   assign new_sboxw = {sb[sboxw[31:24]], sb[sboxw[23:16]], sb[sboxw[15:8]], sb[sboxw[7:0]]};

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from the GF(2^8) inverse followed by the affine map
   function automatic logic [7:0] sbox_entry(input int x);
      logic [7:0] v, inv;
      v = 8'(x); inv = 8'h0;
      for (int y = 1; y < 256; y++) if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   function automatic logic [127:0] pack_ms();
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = ms[i];
      return v;
   endfunction

   task automatic load_key(input logic [255:0] key, input logic kl);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, nw;
      nk = kl ? 8 : 4;
      nw = kl ? 60 : 44;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (4*r + 3 < nw) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else rk[r] = 128'h0;
      end
   endtask

   // Byte array indexed row + 4*column; pre[r] is the state entering SubBytes of round r
   task automatic model_encrypt(input logic kl, input logic [127:0] pt, output logic [127:0] ct);
      logic [7:0] t [16];
      logic [7:0] a [4];
      int nr;
      nr = kl ? 14 : 10;
      for (int i = 0; i < 16; i++) ms[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int r = 1; r <= nr; r++) begin
         pre[r] = pack_ms();
         for (int i = 0; i < 16; i++) t[i] = sb[ms[i]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) ms[q+4*c] = t[q+4*((c+q)%4)];
         if (r < nr) begin
            for (int c = 0; c < 4; c++) begin
               for (int q = 0; q < 4; q++) a[q] = ms[q+4*c];
               for (int q = 0; q < 4; q++)
                  ms[q+4*c] = gmul(8'h02, a[q]) ^ gmul(8'h03, a[(q+1)%4]) ^ a[(q+2)%4] ^ a[(q+3)%4];
            end
         end
         for (int i = 0; i < 16; i++) ms[i] = ms[i] ^ rk[r][127-8*i -: 8];
      end
      ct = pack_ms();
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_aes(input string tag, input logic kl, input logic [127:0] pt,
                          input logic [127:0] exp_ct, input bit b2b, input bit trace,
                          input bit disturb, input int rst_at);
      int k, r, p;
      bit aborted;
      aborted = 1'b0;
      if (!b2b) @(negedge clk);
      check({tag, "_ready_before"}, 128'(ready), 128'(1));
      next = 1'b1; keylen = kl; block = pt;
      @(negedge clk);
      next = 1'b0;
      check({tag, "_hold_at_accept"}, new_block, hold_ct);
      k = 0;
      while (ready === 1'b0 && k < 200 && !aborted) begin
         if (trace) begin
            if (k == 0) begin
               check({tag, "_trace_round"}, 128'(round), 128'(0));
               check({tag, "_trace_sboxw"}, 128'(sboxw), 128'(0));
            end else begin
               r = (k - 1) / 5 + 1;
               p = (k - 1) % 5;
               check({tag, "_trace_round"}, 128'(round), 128'(r));
               check({tag, "_trace_sboxw"}, 128'(sboxw),
                     (p < 4) ? 128'(pre[r][127-32*p -: 32]) : 128'(0));
            end
         end
         if (k == 1) block = {$urandom, $urandom, $urandom, $urandom};
         if (disturb && k == 9) begin
            next = 1'b1; keylen = ~kl; block = {$urandom, $urandom, $urandom, $urandom};
         end
         if (disturb && k == 10) next = 1'b0;
         if (rst_at != 0 && k == rst_at - 1) begin
            reset = 1'b1;
            #1;
            check({tag, "_rst_ready"}, 128'(ready), 128'(1));
            check({tag, "_rst_round"}, 128'(round), 128'(0));
            check({tag, "_rst_block"}, new_block, 128'h0);
            @(negedge clk);
            reset = 1'b0;
            hold_ct = 128'h0;
            aborted = 1'b1;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      if (!aborted) begin
         check({tag, "_latency"}, 128'(k), kl ? 128'(71) : 128'(51));
         check({tag, "_ciphertext"}, new_block, exp_ct);
         hold_ct = new_block;
      end
   endtask

   initial begin
      logic [127:0] mct;
      logic [255:0] rkey;
      logic [127:0] rpt;
      logic         rkl;

      for (int x = 0; x < 256; x++) sb[x] = sbox_entry(x);
      for (int r = 0; r < 16; r++) rk[r] = 128'h0;
      hold_ct = 128'h0;

      repeat (3) @(negedge clk);
      check("reset_ready", 128'(ready), 128'(1));
      check("reset_round", 128'(round), 128'(0));
      check("reset_block", new_block, 128'h0);
      check("reset_sboxw", 128'(sboxw), 128'(0));
      reset = 1'b0;

      load_key(KEY1, 1'b0); model_encrypt(1'b0, PT, mct);
      run_aes("c1_trace", 1'b0, PT, CT1, 1'b0, 1'b1, 1'b0, 0);

      load_key(KEY3, 1'b1); model_encrypt(1'b1, PT, mct);
      run_aes("c3_trace", 1'b1, PT, CT3, 1'b0, 1'b1, 1'b0, 0);

      load_key(KEY1, 1'b0); model_encrypt(1'b0, PT, mct);
      run_aes("c1_disturb", 1'b0, PT, CT1, 1'b0, 1'b0, 1'b1, 0);

      load_key(KEY3, 1'b1); model_encrypt(1'b1, PT, mct);
      run_aes("c3_reset", 1'b1, PT, CT3, 1'b0, 1'b0, 1'b0, 30);
      load_key(KEY1, 1'b0); model_encrypt(1'b0, PT, mct);
      run_aes("c1_after_reset", 1'b0, PT, CT1, 1'b0, 1'b0, 1'b0, 0);

      run_aes("b2b_c1", 1'b0, PT, CT1, 1'b0, 1'b0, 1'b0, 0);
      load_key(KEY3, 1'b1); model_encrypt(1'b1, PT, mct);
      run_aes("b2b_c3", 1'b1, PT, CT3, 1'b1, 1'b1, 1'b0, 0);

      for (int j = 0; j < 6; j++) begin
         rkl  = 1'($urandom % 2);
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rpt  = {$urandom, $urandom, $urandom, $urandom};
         load_key(rkey, rkl);
         model_encrypt(rkl, rpt, mct);
         run_aes("random", rkl, rpt, mct, j[0], 1'b1, 1'b0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
